// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue (instruction buffer
// between fetch and decode). Supplies default widths for the
// INSTRUCTION_SIZE / DATA_SIZE macros when the surrounding build does
// not define them.
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package fetch_queue_pkg;

  // Default number of queue entries (power of two, >= 2).
  localparam int FETCH_QUEUE_DEPTH = 8;

  localparam int INSTR_W    = `INSTRUCTION_SIZE;
  localparam int ENTRY_PC_W = `DATA_SIZE;

  // Decode treats an all-zero opcode as a bubble, so an empty queue
  // presents this word.
  localparam logic [INSTR_W-1:0] NOP_INSTRUCTION = '0;

  // One stored fetch record.
  typedef struct packed {
    logic [INSTR_W-1:0]    instruction;
    logic [ENTRY_PC_W-1:0] pc;
  } fetch_entry_t;

  // Build a stored entry from the fetch-side fields.
  function automatic fetch_entry_t make_entry(
    input logic [INSTR_W-1:0]    instruction,
    input logic [ENTRY_PC_W-1:0] pc
  );
    fetch_entry_t e;
    e.instruction = instruction;
    e.pc          = pc;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x fetch_entry_t register
// array with one synchronous write port and one asynchronous read port.
// The array has no reset; validity is tracked by the queue's count.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FETCH_QUEUE_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  fetch_entry_t      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output fetch_entry_t      rdata
);

  fetch_entry_t mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is purely combinational so the head is visible the cycle
  // after it was written.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of instruction/PC pairs between fetch and
// decode. Holds head/tail pointers and the entry count, applies flush,
// and drives both handshakes.
//
// Handshakes (both sides): a transfer happens at a rising edge exactly
// when valid && ready are both high in the cycle before it. valid never
// depends on the same side's ready. fetch_ready is derived only from
// registered state, so there is no combinational path from dec_ready.
// A full queue refuses a push even in a cycle where decode pops.
//
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty
// and fetch presents an instruction (no flush), that instruction is
// shown to decode in the same cycle; if decode takes it, it is never
// written. Without the macro there is strict one-cycle latency and no
// combinational fetch-to-decode path.
//
// PC_SIZE must not exceed `DATA_SIZE (the stored PC field width).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = FETCH_QUEUE_DEPTH,
  parameter int PC_SIZE = `DATA_SIZE
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fetch_valid,
  input  logic [`INSTRUCTION_SIZE-1:0] fetch_instruction,
  input  logic [PC_SIZE-1:0]         fetch_pc,
  output logic                       fetch_ready,
  output logic                       dec_valid,
  output logic [`INSTRUCTION_SIZE-1:0] dec_instruction,
  output logic [PC_SIZE-1:0]         dec_pc,
  input  logic                       dec_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [CNT_W-1:0]  count;

  logic         queue_valid;
  logic         push_req;
  logic         push;
  logic         pop;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;

  // ---------------------------------------------------------------
  // Status derived from registered state only
  // ---------------------------------------------------------------
  assign queue_valid = (count != '0);
  assign fetch_ready = (count != FULL_COUNT);
  assign occupancy   = count;

  // A flush cancels any push or pop happening in the same cycle.
  assign push_req = fetch_valid && fetch_ready && !flush;
  assign pop      = queue_valid && dec_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  // Empty queue with a live fetch: present the fetch directly.
  assign bypass = !queue_valid && fetch_valid && !flush;

  // A bypassed instruction taken by decode is consumed, never stored.
  assign push = push_req && !(bypass && dec_ready);
`else
  assign push = push_req;
`endif

  // ---------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------
  assign wr_entry = make_entry(fetch_instruction, ENTRY_PC_W'(fetch_pc));

  fetch_queue_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (head_entry)
  );

  // Decode view: head entry when occupied, zeros (bubble) when empty,
  // or the live fetch when bypassing.
  always_comb begin
    dec_valid       = queue_valid;
    dec_instruction = NOP_INSTRUCTION;
    dec_pc          = '0;
    if (queue_valid) begin
      dec_instruction = head_entry.instruction;
      dec_pc          = PC_SIZE'(head_entry.pc);
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      dec_valid       = 1'b1;
      dec_instruction = fetch_instruction;
      dec_pc          = fetch_pc;
    end
`endif
  end

  // ---------------------------------------------------------------
  // Pointer and count state
  // ---------------------------------------------------------------

  // Advance pointers on push/pop; flush empties the queue outright.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + ADDR_W'(1);
      end
      if (pop) begin
        head <= head + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed vector table, hand-written corner
// sequences (simultaneous push/pop, flush priority, async reset, bypass)
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int W     = 64;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        fetch_valid;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        dec_valid;
  logic [31:0] dec_instruction;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        flush;
  logic [3:0]  occupancy;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .PC_SIZE (32)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .fetch_valid       (fetch_valid),
    .fetch_instruction (fetch_instruction),
    .fetch_pc          (fetch_pc),
    .fetch_ready       (fetch_ready),
    .dec_valid         (dec_valid),
    .dec_instruction   (dec_instruction),
    .dec_pc            (dec_pc),
    .dec_ready         (dec_ready),
    .flush             (flush),
    .occupancy         (occupancy)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // Reference model: stored entries oldest-first as {instruction, pc}.
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sampled DUT outputs of the most recent step.
  logic        s_valid;
  logic [31:0] s_instr;
  logic [31:0] s_pc;
  logic        s_ready;
  logic [3:0]  s_occ;

  // One clock cycle: drive inputs after the falling edge, compare the
  // outputs with the model, then let the rising edge happen and update
  // the model from the queue rules.
  task automatic step(input logic fv, input logic [31:0] fi, input logic [31:0] fp,
                      input logic dr, input logic fl);
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_ready;
    int          size;
    @(negedge clk);
    fetch_valid       = fv;
    fetch_instruction = fi;
    fetch_pc          = fp;
    dec_ready         = dr;
    flush             = fl;
    #1;
    size    = exp_q.size();
    m_ready = (size != DEPTH);
    m_valid = 1'b0;
    m_instr = '0;
    m_pc    = '0;
    if (size != 0) begin
      m_valid = 1'b1;
      {m_instr, m_pc} = exp_q[0];
    end else if (BYPASS && fv && !fl) begin
      m_valid = 1'b1;
      m_instr = fi;
      m_pc    = fp;
    end
    s_valid = dec_valid;
    s_instr = dec_instruction;
    s_pc    = dec_pc;
    s_ready = fetch_ready;
    s_occ   = occupancy;
    check("model.dec_valid",   s_valid, m_valid);
    check("model.dec_instr",   s_instr, m_instr);
    check("model.dec_pc",      s_pc,    m_pc);
    check("model.fetch_ready", s_ready, m_ready);
    check("model.occupancy",   s_occ,   size);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else if (size == 0 && m_valid && dr) begin
      // bypassed instruction consumed directly by decode
    end else begin
      if (m_valid && dr) void'(exp_q.pop_front());
      if (fv && m_ready) exp_q.push_back({fi, fp});
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fv;
    logic [31:0] fi;
    logic [31:0] fp;
    logic        dr;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_ready;
    logic [3:0]  e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return 32'h0000_0013 | ((p >> 2) << 20);
  endfunction

  task automatic add_vec(input logic fv, input logic [31:0] fi, input logic [31:0] fp,
                         input logic dr, input logic fl, input logic ev,
                         input logic [31:0] ei, input logic [31:0] ep,
                         input logic er, input logic [3:0] eo);
    vec_t v;
    v.fv = fv; v.fi = fi; v.fp = fp; v.dr = dr; v.fl = fl;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_ready = er; v.e_occ = eo;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    logic [31:0] p;
    // idle after reset, then single pass-through
    add_vec(0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    add_vec(1, 32'h00A0_0093, 32'h1000, 1, 0,   0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 1, 0,   1, 32'h00A0_0093, 32'h1000, 1, 1);
    add_vec(0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    // fill 8 entries with no pops
    for (int i = 0; i < 8; i++) begin
      p = 32'(i * 4);
      add_vec(1, instr_of(p), p, 0, 0,
              (i != 0), (i != 0) ? instr_of(0) : 32'h0, 0, 1, 4'(i));
    end
    // ninth push while full is ignored
    add_vec(1, 32'hFFFF_FFFF, 32'h000D_EAD0, 0, 0,   1, instr_of(0), 0, 0, 8);
    add_vec(0, 0, 0, 0, 0,   1, instr_of(0), 0, 0, 8);
    // pop three
    for (int k = 0; k < 3; k++) begin
      p = 32'(k * 4);
      add_vec(0, 0, 0, 1, 0,   1, instr_of(p), p, (k != 0), 4'(8 - k));
    end
    // push three more, tail wraps
    for (int k = 0; k < 3; k++) begin
      p = 32'h20 + 32'(k * 4);
      add_vec(1, instr_of(p), p, 0, 0,   1, instr_of(32'h0C), 32'h0C, 1, 4'(5 + k));
    end
    // drain: 0x0C .. 0x28 in order
    for (int k = 0; k < 8; k++) begin
      p = 32'h0C + 32'(k * 4);
      add_vec(0, 0, 0, 1, 0,   1, instr_of(p), p, (k != 0), 4'(8 - k));
    end
    add_vec(0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] seq;

  initial begin
    reset_n           = 1'b0;
    fetch_valid       = 1'b0;
    fetch_instruction = '0;
    fetch_pc          = '0;
    dec_ready         = 1'b0;
    flush             = 1'b0;
    seq               = 32'h100;

    // reset values while reset_n is low
    @(negedge clk);
    #1;
    check("rst.dec_valid",   dec_valid, 0);
    check("rst.dec_instr",   dec_instruction, 0);
    check("rst.dec_pc",      dec_pc, 0);
    check("rst.fetch_ready", fetch_ready, 1);
    check("rst.occupancy",   occupancy, 0);
    @(negedge clk);
    reset_n = 1'b1;

`ifndef FETCH_QUEUE_BYPASS_EN
    build_table();
    foreach (vecs[i]) begin
      step(vecs[i].fv, vecs[i].fi, vecs[i].fp, vecs[i].dr, vecs[i].fl);
      check($sformatf("vec%0d.dec_valid", i),   s_valid, vecs[i].e_valid);
      check($sformatf("vec%0d.dec_instr", i),   s_instr, vecs[i].e_instr);
      check($sformatf("vec%0d.dec_pc", i),      s_pc,    vecs[i].e_pc);
      check($sformatf("vec%0d.fetch_ready", i), s_ready, vecs[i].e_ready);
      check($sformatf("vec%0d.occupancy", i),   s_occ,   vecs[i].e_occ);
    end
`endif

    // simultaneous push/pop at occupancy 4 keeps occupancy and order
    for (int i = 0; i < 4; i++) begin
      step(1, $urandom, seq, 0, 0);
      seq += 4;
    end
    for (int i = 0; i < 10; i++) begin
      step(1, $urandom, seq, 1, 0);
      seq += 4;
      check("pushpop.occupancy", s_occ, 4);
    end
    step(0, 0, 0, 0, 0);
    check("pushpop.after", s_occ, 4);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 1, 0);
    check("pushpop.drained", s_occ, 0);

    // flush beats concurrent push and pop
    for (int i = 0; i < 5; i++) begin
      step(1, $urandom, seq, 0, 0);
      seq += 4;
    end
    step(1, 32'h1234_5677, 32'h0BAD_0000, 1, 1);
    check("flush.pre_occ", s_occ, 5);
    step(0, 0, 0, 0, 0);
    check("flush.dec_valid", s_valid, 0);
    check("flush.dec_instr", s_instr, 0);
    check("flush.occupancy", s_occ, 0);
    step(0, 0, 0, 0, 1);   // flush while empty
    step(0, 0, 0, 0, 0);
    check("flush_empty.occupancy", s_occ, 0);

    // asynchronous reset between edges at occupancy 3
    for (int i = 0; i < 3; i++) begin
      step(1, $urandom, seq, 0, 0);
      seq += 4;
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    dec_ready   = 1'b0;
    flush       = 1'b0;
    #1;
    check("arst.pre_occ", occupancy, 3);
    check("arst.pre_valid", dec_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst.dec_valid",   dec_valid, 0);
    check("arst.occupancy",   occupancy, 0);
    check("arst.dec_instr",   dec_instruction, 0);
    check("arst.fetch_ready", fetch_ready, 1);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0);
    check("arst.after_release", s_occ, 0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // zero-latency bypass on an empty queue
    step(1, 32'h00A0_0093, 32'h2000, 1, 0);
    check("bypass.dec_valid", s_valid, 1);
    check("bypass.dec_instr", s_instr, 32'h00A0_0093);
    check("bypass.dec_pc",    s_pc, 32'h2000);
    step(0, 0, 0, 0, 0);
    check("bypass.occupancy", s_occ, 0);
    step(1, 32'h0000_0113, 32'h2004, 0, 0);
    check("bypass_hold.dec_valid", s_valid, 1);
    step(0, 0, 0, 0, 0);
    check("bypass_hold.occupancy", s_occ, 1);
    step(0, 0, 0, 1, 0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, seq,
           $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      seq += 4;
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 1, 0);
    check("final.occupancy", s_occ, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
